// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer: LCD panel power-up/down sequencer; define LCD_BL_PWM_EN for PWM backlight with brightness input
module lcd_power_sequencer #(
    parameter int CNT_W     = 24,
    parameter int T_VDD     = 1000,
    parameter int T_BL      = 5000,
    parameter int N_FRAMES  = 3,
    parameter int T_OFF     = 10000,
    parameter int FRAME_TMO = 2000000
`ifdef LCD_BL_PWM_EN
    ,
    parameter int PWM_W     = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             power_on_req,
    input  logic             frame_start,
`ifdef LCD_BL_PWM_EN
    input  logic [PWM_W-1:0] brightness,
`endif
    output logic             panel_vdd_en,
    output logic             timing_en,
    output logic             disp_on,
    output logic             backlight_en,
    output logic             ready,
    output logic             busy,
    output logic             fault
);
    typedef enum logic [3:0] {
        OFF, VDD_UP, TIM_UP, DISP_UP, ON, BL_DN, DISP_DN, VDD_DN, OFF_HOLD
    } state_t;
    localparam logic [CNT_W-1:0] VDD_L  = CNT_W'((T_VDD     == 0 ? 1 : T_VDD)     - 1);
    localparam logic [CNT_W-1:0] BL_L   = CNT_W'((T_BL      == 0 ? 1 : T_BL)      - 1);
    localparam logic [CNT_W-1:0] OFF_L  = CNT_W'((T_OFF     == 0 ? 1 : T_OFF)     - 1);
    localparam logic [CNT_W-1:0] TMO_L  = CNT_W'((FRAME_TMO == 0 ? 1 : FRAME_TMO) - 1);
    localparam logic [CNT_W-1:0] FRM_L  = CNT_W'((N_FRAMES  == 0 ? 1 : N_FRAMES)  - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, frm_q, frm_d;
    logic             fault_q, fault_d;
    logic             on_lvl;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(~&cnt_q);
        frm_d   = frm_q;
        fault_d = fault_q;
        case (state_q)
            OFF: if (power_on_req) begin
                state_d = VDD_UP;
                fault_d = 1'b0;
            end
            VDD_UP:   state_d = !power_on_req ? VDD_DN : (cnt_q == VDD_L ? TIM_UP : VDD_UP);
            DISP_UP:  state_d = !power_on_req ? DISP_DN : (cnt_q == BL_L ? ON : DISP_UP);
            ON:       state_d = !power_on_req ? BL_DN : ON;
            BL_DN:    state_d = cnt_q == BL_L ? DISP_DN : BL_DN;
            VDD_DN:   state_d = cnt_q == VDD_L ? OFF_HOLD : VDD_DN;
            OFF_HOLD: state_d = cnt_q == OFF_L ? OFF : OFF_HOLD;
            TIM_UP, DISP_DN: begin
                // frame counting with watchdog; an abort in TIM_UP wins over a same-cycle exit
                if (state_q == TIM_UP && !power_on_req)
                    state_d = VDD_DN;
                else if (frame_start) begin
                    cnt_d = '0;
                    frm_d = frm_q + CNT_W'(~&frm_q);
                    if (frm_q >= FRM_L)
                        state_d = state_q == TIM_UP ? DISP_UP : VDD_DN;
                end else if (cnt_q == TMO_L) begin
                    fault_d = 1'b1;
                    state_d = VDD_DN;
                end
            end
            default: state_d = OFF;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            frm_d = '0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            frm_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            fault_q <= fault_d;
        end
    end
    assign panel_vdd_en = state_q != OFF && state_q != OFF_HOLD;
    assign timing_en    = state_q inside {TIM_UP, DISP_UP, ON, BL_DN, DISP_DN};
    assign disp_on      = state_q inside {DISP_UP, ON, BL_DN};
    assign ready        = state_q == ON;
    assign busy         = state_q != OFF && state_q != ON;
    assign fault        = fault_q;
    assign on_lvl       = state_q == ON;
`ifdef LCD_BL_PWM_EN
    logic [PWM_W-1:0] p_q, p_d;
    assign p_d = p_q + 1'b1;
    always_ff @(posedge clock) begin
        if (reset)
            p_q <= '0;
        else
            p_q <= p_d;
    end
    assign backlight_en = on_lvl && (p_q < brightness);
`else
    assign backlight_en = on_lvl;
`endif
endmodule
